// File: rtl/lsu_bus_if_if.sv
// Data-memory bus between the LSU and the external memory.
// The master drives the request and write payload; the slave answers
// with grant and read data.
interface lsu_bus_if_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns the core's single-cycle memory access into a
// req/gnt/rvalid bus transaction and stalls the core until it completes.
// Stores get byte-lane steering; loads get sign/zero extension.
// Optional feature macro: LSU_TIMEOUT_EN (watchdog on REQ/WAIT; on expiry
// the access is aborted with an error pulse and zero load data).
module lsu_bus_if #(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_req,
  input  logic               lsu_we,
  input  logic [2:0]         lsu_funct3,
  input  logic [31:0]        lsu_addr,
  input  logic [31:0]        lsu_wdata,
  output logic [31:0]        lsu_rdata,
  output logic               lsu_stall,
  output logic               lsu_err,
  lsu_bus_if_if.master       mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_bus_if: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        illegal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] addr_off;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd;
  logic [7:0] wd_nxt;
  logic       err_q;
  assign wd_nxt = wd + 8'd1;
`endif

  // Decode reserved funct3 codes, load-only codes used by a store, and misalignment.
  always_comb begin
    illegal = 1'b0;
    case (lsu_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = lsu_addr[0];
      3'b010:  illegal = |lsu_addr[1:0];
      3'b100:  illegal = lsu_we;
      3'b101:  illegal = lsu_we | lsu_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Store lane steering; loads always read the full word.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = lsu_wdata;
    if (lsu_we) begin
      case (lsu_funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << lsu_addr[1:0];
          wdata_c = {4{lsu_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << lsu_addr[1:0];
          wdata_c = {2{lsu_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign addr_off = lsu_addr - MEM_BASE;

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    case (lane_q)
      2'd0:    rbyte = mem.rdata[7:0];
      2'd1:    rbyte = mem.rdata[15:8];
      2'd2:    rbyte = mem.rdata[23:16];
      default: rbyte = mem.rdata[31:24];
    endcase
    rhalf = lane_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'h0, rbyte};
      3'b101:  ext = {16'h0, rhalf};
      default: ext = mem.rdata;
    endcase
  end

  // Access FSM with registered bus outputs and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.be    <= 4'b0;
      mem.addr  <= 32'h0;
      mem.wdata <= 32'h0;
      lsu_rdata <= 32'h0;
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      lane_q    <= 2'b0;
`ifdef LSU_TIMEOUT_EN
      wd        <= 8'h0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (lsu_req && !illegal) begin
            we_q      <= lsu_we;
            f3_q      <= lsu_funct3;
            lane_q    <= lsu_addr[1:0];
            mem.req   <= 1'b1;
            mem.we    <= lsu_we;
            mem.be    <= be_c;
            mem.addr  <= {addr_off[31:2], 2'b00};
            mem.wdata <= wdata_c;
            state     <= REQ;
`ifdef LSU_TIMEOUT_EN
            wd        <= 8'h0;
`endif
          end
        end
        REQ: begin
`ifdef LSU_TIMEOUT_EN
          wd <= wd_nxt;
`endif
          if (mem.gnt) begin
            mem.req <= 1'b0;
            state   <= we_q ? DONE : WAIT;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wd_nxt == WD_LIMIT) begin
            mem.req   <= 1'b0;
            err_q     <= 1'b1;
            lsu_rdata <= 32'h0;
            state     <= DONE;
          end
`endif
        end
        WAIT: begin
`ifdef LSU_TIMEOUT_EN
          wd <= wd_nxt;
`endif
          if (mem.rvalid) begin
            lsu_rdata <= ext;
            state     <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wd_nxt == WD_LIMIT) begin
            err_q     <= 1'b1;
            lsu_rdata <= 32'h0;
            state     <= DONE;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_stall = lsu_req & (state != DONE) & ~illegal;

`ifdef LSU_TIMEOUT_EN
  assign lsu_err = ((state == IDLE) & lsu_req & illegal) | err_q;
`else
  assign lsu_err = (state == IDLE) & lsu_req & illegal;
`endif

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: resets, load extension, delayed-grant
// store, illegal accesses, reset mid-access, back-to-back access and,
// when LSU_TIMEOUT_EN is defined, the watchdog abort.
module tb_lsu_bus_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        lsu_err;

  lsu_bus_if_if mem ();

  lsu_bus_if #(.MEM_BASE(32'h0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall), .lsu_err(lsu_err),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Results of the last run_access call.
  int          st, rq;
  logic        es, sb, hg;
  logic [3:0]  be_o;
  logic [31:0] ad_o, wd_o, rd_o;

  // Issue one access and act as memory: gnt after gnt_wait REQ cycles,
  // rvalid the cycle after gnt. Samples at negedge, stops when stall drops.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int gnt_wait);
    logic granted;
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    mem.rdata = rword; mem.gnt = 1'b0; mem.rvalid = 1'b0;
    st = 0; rq = 0; es = 1'b0; sb = 1'b1; hg = 1'b1; granted = 1'b0;
    be_o = 4'h0; ad_o = 32'h0; wd_o = 32'h0; rd_o = 32'h0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (lsu_err) es = 1'b1;
      if (mem.req) begin
        if (rq == 0) begin
          be_o = mem.be; ad_o = mem.addr; wd_o = mem.wdata;
        end else if (mem.be !== be_o || mem.addr !== ad_o || mem.wdata !== wd_o) begin
          sb = 1'b0;
        end
        rq++;
      end
      if (!lsu_stall) begin
        rd_o = lsu_rdata; hg = 1'b0;
        break;
      end
      st++;
      mem.rvalid = granted;
      mem.gnt = mem.req && (rq > gnt_wait);
      if (mem.gnt) granted = 1'b1;
    end
    @(posedge clk); #1;
    lsu_req = 1'b0; mem.gnt = 1'b0; mem.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    mem.gnt = 1'b1; mem.rvalid = 1'b1; mem.rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem.req !== 1'b0) begin errs++; $display("FAIL reset_mem_req got=%b exp=0", mem.req); end
    checks++; if (mem.be !== 4'h0 || mem.addr !== 32'h0 || mem.wdata !== 32'h0 || mem.we !== 1'b0) begin
      errs++; $display("FAIL reset_mem_bus got be=%h addr=%h wdata=%h we=%b exp all 0", mem.be, mem.addr, mem.wdata, mem.we); end
    checks++; if (lsu_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got=%h exp=0", lsu_rdata); end
    checks++; if (lsu_stall !== 1'b0 || lsu_err !== 1'b0) begin
      errs++; $display("FAIL reset_stall_err got stall=%b err=%b exp 0 0", lsu_stall, lsu_err); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (lsu_rdata !== 32'h0 || mem.req !== 1'b0) begin
      errs++; $display("FAIL reset_stale_rvalid got rdata=%h req=%b exp 0 0", lsu_rdata, mem.req); end
    mem.gnt = 1'b0; mem.rvalid = 1'b0;
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    checks++; if (hg) begin errs++; $display("FAIL lw_hang got=hung exp=done"); end
    checks++; if (st !== 3) begin errs++; $display("FAIL lw_stalls got=%0d exp=3", st); end
    checks++; if (be_o !== 4'b1111 || ad_o !== 32'h100) begin
      errs++; $display("FAIL lw_bus got be=%b addr=%h exp be=1111 addr=00000100", be_o, ad_o); end
    checks++; if (rd_o !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd_o); end
    checks++; if (rq !== 1 || es !== 1'b0) begin errs++; $display("FAIL lw_req_err got req_cycles=%0d err=%b exp 1 0", rq, es); end
  endtask

  task automatic test_load_ext();
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 0);
    checks++; if (rd_o !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_sign got=%h exp=ffffff80", rd_o); end
    checks++; if (ad_o !== 32'h100 || be_o !== 4'b1111) begin
      errs++; $display("FAIL lb_bus got addr=%h be=%b exp addr=00000100 be=1111", ad_o, be_o); end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 0);
    checks++; if (rd_o !== 32'h0000_0080) begin errs++; $display("FAIL lbu_zero got=%h exp=00000080", rd_o); end
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h8012_3456, 0);
    checks++; if (rd_o !== 32'h0000_8012) begin errs++; $display("FAIL lhu_zero got=%h exp=00008012", rd_o); end
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8012_3456, 0);
    checks++; if (rd_o !== 32'hFFFF_8012) begin errs++; $display("FAIL lh_sign got=%h exp=ffff8012", rd_o); end
    run_access(1'b0, 3'b000, 32'h100, 32'h0, 32'h8012_3456, 0);
    checks++; if (rd_o !== 32'h0000_0056) begin errs++; $display("FAIL lb_lane0 got=%h exp=00000056", rd_o); end
  endtask

  task automatic test_store();
    run_access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3);
    checks++; if (be_o !== 4'b1100 || wd_o !== 32'hABCD_ABCD || ad_o !== 32'h200) begin
      errs++; $display("FAIL sh_bus got be=%b wdata=%h addr=%h exp be=1100 wdata=abcdabcd addr=00000200", be_o, wd_o, ad_o); end
    checks++; if (sb !== 1'b1 || rq !== 4) begin
      errs++; $display("FAIL sh_hold got stable=%b req_cycles=%0d exp 1 4", sb, rq); end
    checks++; if (st !== 5) begin errs++; $display("FAIL sh_stalls got=%0d exp=5", st); end
    run_access(1'b1, 3'b000, 32'h201, 32'h0000_00EF, 32'h0, 0);
    checks++; if (be_o !== 4'b0010 || wd_o !== 32'hEFEF_EFEF || st !== 2) begin
      errs++; $display("FAIL sb_bus got be=%b wdata=%h stalls=%0d exp be=0010 wdata=efefefef stalls=2", be_o, wd_o, st); end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    checks++; if (es !== 1'b1 || rq !== 0 || st !== 0) begin
      errs++; $display("FAIL lw_misalign got err=%b req_cycles=%0d stalls=%0d exp 1 0 0", es, rq, st); end
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    checks++; if (es !== 1'b1 || rq !== 0 || st !== 0) begin
      errs++; $display("FAIL f3_011 got err=%b req_cycles=%0d stalls=%0d exp 1 0 0", es, rq, st); end
    run_access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    checks++; if (es !== 1'b1 || rq !== 0 || st !== 0) begin
      errs++; $display("FAIL store_f3_100 got err=%b req_cycles=%0d stalls=%0d exp 1 0 0", es, rq, st); end
    run_access(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0);
    checks++; if (es !== 1'b1 || rq !== 0 || st !== 0) begin
      errs++; $display("FAIL sh_misalign got err=%b req_cycles=%0d stalls=%0d exp 1 0 0", es, rq, st); end
    @(negedge clk);
    checks++; if (mem.req !== 1'b0 || lsu_err !== 1'b0) begin
      errs++; $display("FAIL illegal_after got req=%b err=%b exp 0 0", mem.req, lsu_err); end
  endtask

  task automatic test_rst_in_wait();
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h180;
    mem.rdata = 32'hCAFE_F00D; mem.gnt = 1'b1; mem.rvalid = 1'b0;
    @(posedge clk); #1;   // now in REQ, gnt seen at next edge
    @(posedge clk); #1;   // now in WAIT
    mem.gnt = 1'b0; rst = 1'b1; lsu_req = 1'b0;
    @(posedge clk); #1;   // reset taken
    rst = 1'b0; mem.rvalid = 1'b1;
    @(posedge clk); #1;
    mem.rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (lsu_rdata !== 32'h0 || mem.req !== 1'b0 || lsu_stall !== 1'b0) begin
        errs++; $display("FAIL rst_wait_c%0d got rdata=%h req=%b stall=%b exp 0 0 0", c, lsu_rdata, mem.req, lsu_stall); end
    end
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h1357_9BDF, 0);
    checks++; if (st !== 3 || rd_o !== 32'h1357_9BDF) begin
      errs++; $display("FAIL rst_recover got stalls=%0d rdata=%h exp 3 13579bdf", st, rd_o); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b010, 32'h204, 32'h1234_5678, 32'h0, 0);
    checks++; if (be_o !== 4'b1111 || wd_o !== 32'h1234_5678 || ad_o !== 32'h204 || st !== 2) begin
      errs++; $display("FAIL b2b_sw got be=%b wdata=%h addr=%h stalls=%0d exp 1111 12345678 00000204 2", be_o, wd_o, ad_o, st); end
    run_access(1'b0, 3'b100, 32'h201, 32'h0, 32'hA5C3_7E11, 0);
    checks++; if (rd_o !== 32'h0000_007E || st !== 3) begin
      errs++; $display("FAIL b2b_lbu got rdata=%h stalls=%0d exp 0000007e 3", rd_o, st); end
    run_access(1'b0, 3'b010, 32'h208, 32'h0, 32'h0BAD_F00D, 2);
    checks++; if (rd_o !== 32'h0BAD_F00D || st !== 5) begin
      errs++; $display("FAIL b2b_lw_wait got rdata=%h stalls=%0d exp 0badf00d 5", rd_o, st); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, 1000);
    checks++; if (hg) begin errs++; $display("FAIL to_hang got=hung exp=done"); end
    checks++; if (rq !== 8 || st !== 9) begin
      errs++; $display("FAIL to_cycles got req_cycles=%0d stalls=%0d exp 8 9", rq, st); end
    checks++; if (es !== 1'b1 || rd_o !== 32'h0) begin
      errs++; $display("FAIL to_err_rdata got err=%b rdata=%h exp 1 0", es, rd_o); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_illegal();
    test_rst_in_wait();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
